// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity modes and bit-timing helper
// for the extended UART receiver (parity state needs UART_RX_PARITY_EN).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK_WAIT
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: 2-FF line synchroniser, per-bit counter and
// 3-sample majority vote around the bit centre.
module uart_bit_sampler #(
    parameter int CPB = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    input  logic start_i,
    input  logic run_i,
    output logic line_o,
    output logic fall_edge_o,
    output logic bit_value_o,
    output logic bit_strobe_o,
    output logic bit_end_o
);
    localparam int H  = CPB / 2;
    localparam int CW = $clog2(CPB);
    localparam logic [CW-1:0] C_S0   = CW'(H - 1);
    localparam logic [CW-1:0] C_S1   = CW'(H);
    localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);

    logic [1:0]    sync_q, sync_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    smp_q, smp_d;

    assign line_o      = sync_q[1];
    assign fall_edge_o = prev_q & ~sync_q[1];

    always_comb begin
        sync_d = {sync_q[0], line_i};
        smp_d  = smp_q;
        // Count 0 is the edge-detect cycle itself, so a new frame starts at 1.
        if (start_i)
            cnt_d = CW'(1);
        else if (run_i)
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
        else
            cnt_d = '0;
        if (cnt_q == C_S0) smp_d[0] = sync_q[1];
        if (cnt_q == C_S1) smp_d[1] = sync_q[1];
    end

    always_comb begin
        bit_strobe_o = run_i && (cnt_q == C_DEC);
        bit_end_o    = run_i && (cnt_q == C_LAST);
        bit_value_o  = (smp_q[0] & smp_q[1])
                     | (smp_q[0] & sync_q[1])
                     | (smp_q[1] & sync_q[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            cnt_q  <= '0;
            smp_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[1];
            cnt_q  <= cnt_d;
            smp_q  <= smp_d;
        end
    end

endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: parametrised UART receiver with break detect and a
// valid/ready output; parity is compiled in only with UART_RX_PARITY_EN.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 2_500_000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_data,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);

    if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN))
    begin : g_bad_cfg
        $error("uart_rx_ext: unsupported configuration");
    end

    state_e state_q, state_d;
    logic   line, fall_edge, bit_value, bit_strobe, bit_end;
    logic   run, start, stop_dec, brk_hit, done;

    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 zero_q, zero_d, ferr_q, ferr_d;
    logic                 valid_q, valid_d, fflag_q, fflag_d;
    logic                 ovr_q, ovr_d, brk_q, brk_d;

`ifdef UART_RX_PARITY_EN
    localparam int PAR = PARITY;
    logic perr_q, perr_d, pflag_q, pflag_d, exp_par;
    assign exp_par    = (PAR == PAR_ODD) ? ~^shift_q : ^shift_q;
    assign parity_err = pflag_q;
`else
    assign parity_err = 1'b0;
`endif

    uart_bit_sampler #(.CPB(CPB)) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .line_i       (in_data),
        .start_i      (start),
        .run_i        (run),
        .line_o       (line),
        .fall_edge_o  (fall_edge),
        .bit_value_o  (bit_value),
        .bit_strobe_o (bit_strobe),
        .bit_end_o    (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (fall_edge) state_d = START;
            START:      if (bit_strobe && bit_value) state_d = IDLE;
                        else if (bit_end) state_d = DATA;
`ifdef UART_RX_PARITY_EN
            DATA:       if (bit_end && idx_q == LAST_D)
                            state_d = (PAR != PAR_NONE) ? uart_pkg::PARITY : STOP;
            uart_pkg::PARITY:
                        if (bit_end) state_d = STOP;
`else
            DATA:       if (bit_end && idx_q == LAST_D) state_d = STOP;
`endif
            STOP:       if (brk_hit) state_d = BREAK_WAIT;
                        else if (done) state_d = IDLE;
            BREAK_WAIT: if (line) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        run      = (state_q != IDLE) && (state_q != BREAK_WAIT);
        start    = (state_q == IDLE) && fall_edge;
        stop_dec = (state_q == STOP) && bit_strobe;
        brk_hit  = stop_dec && (idx_q == 4'd0) && zero_q && !bit_value;
        done     = stop_dec && !brk_hit && (idx_q == LAST_S);
    end

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        zero_d  = zero_q;
        ferr_d  = ferr_q;
        data_d  = data_q;
        valid_d = valid_q;
        fflag_d = fflag_q;
        ovr_d   = 1'b0;
        brk_d   = brk_hit;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
        pflag_d = pflag_q;
`endif
        if (state_d != state_q) idx_d = '0;
        else if (bit_end)       idx_d = idx_q + 4'd1;
        if (start) begin
            zero_d = 1'b1;
            ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d = 1'b0;
`endif
        end
        if (bit_strobe && state_q == DATA) begin
            shift_d = {bit_value, shift_q[DATA_BITS-1:1]};
            if (bit_value) zero_d = 1'b0;
        end
`ifdef UART_RX_PARITY_EN
        if (bit_strobe && state_q == uart_pkg::PARITY) begin
            if (bit_value) zero_d = 1'b0;
            if (bit_value != exp_par) perr_d = 1'b1;
        end
`endif
        if (stop_dec && !bit_value) ferr_d = 1'b1;
        if (valid_q && out_ready) valid_d = 1'b0;
        // A held, unaccepted word wins; the new one is dropped.
        if (done) begin
            if (!valid_q || out_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                fflag_d = ferr_q | ~bit_value;
`ifdef UART_RX_PARITY_EN
                pflag_d = perr_q;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            shift_q <= '0;
            zero_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fflag_q <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
            pflag_q <= 1'b0;
`endif
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
            zero_q  <= zero_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fflag_q <= fflag_d;
            ovr_q   <= ovr_d;
            brk_q   <= brk_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
            pflag_q <= pflag_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign frame_err = fflag_q;
    assign overrun   = ovr_q;
    assign break_det = brk_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: directed frames against uart_rx_ext at 20 clocks/bit,
// one 8N1 instance and one 8E1 instance.
module tb_uart_rx_ext;
    localparam int CPB = 20;

`ifdef UART_RX_PARITY_EN
    localparam logic EXP_PERR1 = 1'b1;
    localparam logic EXP_FERR2 = 1'b0;
`else
    localparam logic EXP_PERR1 = 1'b0;
    localparam logic EXP_FERR2 = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic rx_p = 1'b1;
    logic ready = 1'b1;
    logic ready_p = 1'b0;
    logic [7:0] dout, dout_p;
    logic vld, perr, ferr, ovr, brk;
    logic vld_p, perr_p, ferr_p, ovr_p, brk_p;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic [9:0] cap [0:63];
    int cap_n = 0, vld_n = 0, ovr_n = 0, brk_n = 0, rise_cyc = 0;
    logic prev_v = 1'b0;

    always #10 clk = ~clk;

    uart_rx_ext #(
        .CLK_FREQ(50_000_000), .BAUD(2_500_000),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .in_data(rx),
        .out_data(dout), .out_valid(vld), .out_ready(ready),
        .parity_err(perr), .frame_err(ferr),
        .overrun(ovr), .break_det(brk)
    );

    uart_rx_ext #(
        .CLK_FREQ(50_000_000), .BAUD(2_500_000),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) dut_p (
        .clk(clk), .rst(rst), .in_data(rx_p),
        .out_data(dout_p), .out_valid(vld_p), .out_ready(ready_p),
        .parity_err(perr_p), .frame_err(ferr_p),
        .overrun(ovr_p), .break_det(brk_p)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_v <= vld;
        if (vld && !prev_v) rise_cyc <= cyc;
        if (vld) vld_n <= vld_n + 1;
        if (vld && ready) begin
            cap[cap_n[5:0]] <= {ferr, perr, dout};
            cap_n <= cap_n + 1;
        end
        if (ovr) ovr_n <= ovr_n + 1;
        if (brk) brk_n <= brk_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx = v;
        tick(CPB);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input int pm,
                        input bit flip, input logic stop_v);
        start_cyc = cyc;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (pm != 0) drive_bit(sel, ((pm == 2) ? ^d : ~^d) ^ flip);
        drive_bit(sel, stop_v);
        if (sel) rx_p = 1'b1;
        else     rx = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data"}, 32'(dout), 0);
        check({tag, "_valid"}, 32'(vld), 0);
        check({tag, "_perr"}, 32'(perr), 0);
        check({tag, "_ferr"}, 32'(ferr), 0);
        check({tag, "_ovr"}, 32'(ovr), 0);
        check({tag, "_brk"}, 32'(brk), 0);
    endtask

    initial begin
        int c0, v0, o0, b0;
        logic [7:0] d;

        tick(3);
        check_reset("rst");
        rst = 1'b0;
        tick(5);

        c0 = cap_n; v0 = vld_n;
        send(0, 8'h55, 0, 0, 1'b1);
        tick(10);
        check("t1_count", cap_n - c0, 1);
        check("t1_word", 32'(cap[c0]), 32'h055);
        check("t1_vcyc", vld_n - v0, 1);
        check("t1_lat", rise_cyc - start_cyc, 194);

        c0 = cap_n; o0 = ovr_n;
        send(0, 8'h55, 0, 0, 1'b1);
        send(0, 8'hBC, 0, 0, 1'b1);
        tick(10);
        check("t2_count", cap_n - c0, 2);
        check("t2_w0", 32'(cap[c0]), 32'h055);
        check("t2_w1", 32'(cap[c0 + 1]), 32'h0BC);
        check("t2_ovr", ovr_n - o0, 0);

        c0 = cap_n;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(3 * CPB);
        check("t3_none", cap_n - c0, 0);
        check("t3_idle", 32'(dut.state_q), 0);
        send(0, 8'hA3, 0, 0, 1'b1);
        tick(10);
        check("t3_count", cap_n - c0, 1);
        check("t3_word", 32'(cap[c0]), 32'h0A3);

        send(1, 8'h0F, 2, 1, 1'b1);
        tick(10);
        check("t4_valid", 32'(vld_p), 1);
        check("t4_data", 32'(dout_p), 32'h0F);
        check("t4_perr", 32'(perr_p), 32'(EXP_PERR1));
        check("t4_ferr", 32'(ferr_p), 0);
        ready_p = 1'b1;
        tick(1);
        ready_p = 1'b0;
        check("t4_drop", 32'(vld_p), 0);
        send(1, 8'h0F, 2, 0, 1'b1);
        tick(10);
        check("t4b_data", 32'(dout_p), 32'h0F);
        check("t4b_perr", 32'(perr_p), 0);
        check("t4b_ferr", 32'(ferr_p), 32'(EXP_FERR2));
        check("t4b_side", 32'({ovr_p, brk_p}), 0);

        ready = 1'b0;
        c0 = cap_n; o0 = ovr_n;
        send(0, 8'h11, 0, 0, 1'b1);
        tick(CPB);
        send(0, 8'h22, 0, 0, 1'b1);
        tick(10);
        check("t5_data", 32'(dout), 32'h11);
        check("t5_valid", 32'(vld), 1);
        check("t5_ferr", 32'(ferr), 0);
        check("t5_ovr", ovr_n - o0, 1);
        ready = 1'b1;
        tick(2);
        check("t5_count", cap_n - c0, 1);
        check("t5_word", 32'(cap[c0]), 32'h011);
        check("t5_drop", 32'(vld), 0);

        c0 = cap_n; b0 = brk_n;
        rx = 1'b0;
        tick(12 * CPB);
        rx = 1'b1;
        tick(2 * CPB);
        check("t6_brk", brk_n - b0, 1);
        check("t6_none", cap_n - c0, 0);
        send(0, 8'h7E, 0, 0, 1'b1);
        tick(10);
        check("t6_count", cap_n - c0, 1);
        check("t6_word", 32'(cap[c0]), 32'h07E);

        c0 = cap_n;
        d = 8'hC3;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
        rx = d[4];
        tick(CPB / 2);
        rst = 1'b1;
        rx = 1'b1;
        tick(1);
        check_reset("t7");
        rst = 1'b0;
        tick(2 * CPB);
        send(0, 8'hC3, 0, 0, 1'b1);
        tick(10);
        check("t7_count", cap_n - c0, 1);
        check("t7_word", 32'(cap[c0]), 32'h0C3);

        c0 = cap_n;
        send(0, 8'h3C, 0, 0, 1'b0);
        tick(10);
        check("t8_count", cap_n - c0, 1);
        check("t8_word", 32'(cap[c0]), 32'h23C);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver, successor to the fixed 8N1 receiver: configurable data width, parity and stop bits, with a 3-sample majority vote, start-bit glitch rejection and a valid/ready output handshake. It sits between the RS-232 pin (after the board buffer) and any byte consumer, such as a command parser or FIFO. Error conditions are reported per frame as sideband flags, and as pulses.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 2_500_000: line bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division; must be ≥ 4.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  1  asynchronous serial line; idles high.
- out_data  out  DATA_BITS  received word, LSB = first data bit on the line.
- out_valid  out  1  out_data and flags hold a word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- parity_err  out  1  sideband flag; meaningful while out_valid.
- frame_err  out  1  sideband flag; meaningful while out_valid.
- overrun  out  1  one-cycle pulse when a completed word is dropped.
- break_det  out  1  one-cycle pulse when a break is detected.

## Operation
- in_data passes through a 2-FF synchroniser. Both stages reset to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- Per-bit counter: counts 0..CLKS_PER_BIT-1 from the bit start. Let H = CLKS_PER_BIT/2.
  - Samples are taken at counts H-1, H and H+1.
  - The bit value is the majority of the three samples, decided at count H+1.
- IDLE → START on a 1→0 transition of the synchronised line. The counter starts at 0 on that cycle.
- START: if the majority is 1, treat it as a glitch and return to IDLE with no output. Otherwise go to DATA at count CLKS_PER_BIT-1.
- DATA: shift in DATA_BITS bits, LSB first. Then go to PARITY if PARITY≠0, else STOP.
- PARITY: compare the received bit with the computed parity. A mismatch sets the pending parity_err.
- STOP: check STOP_BITS bits. Any stop bit sampled 0 sets the pending frame_err.
- Break: if every data bit, the parity bit and the first stop bit are all 0:
  - pulse break_det;
  - deliver no word;
  - enter BREAK_WAIT, which returns to IDLE on the first synchronised 1.
- Frame end: at the last stop-bit decision, the FSM goes to IDLE on the next cycle. A new start edge in the remainder of the stop bit is accepted.
- Delivery, at the cycle after the last stop-bit decision:
  - Holding register free, or accepted this cycle (out_valid && out_ready): load out_data and both flags; out_valid = 1.
  - Holding register full and not accepted: pulse overrun; drop the new word; keep the old data and flags.
- When the consumer accepts and no new word loads in that cycle, out_valid drops the next cycle.
- rst mid-frame: everything returns to reset values on the next edge. A partial frame is discarded.

## Timing
- Reset values:
  - out_data = 0, out_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, break_det = 0.
  - FSM = IDLE; both synchroniser stages = 1.
- Latency: from the in_data falling edge reaching the pin, out_valid rises 2 + (1 + DATA_BITS + P + STOP_BITS - 1)·CLKS_PER_BIT + H + 2 cycles, where P = 1 if PARITY≠0, else 0.
  - Sync delay is 2 cycles; the decision is at H+1; the load takes +1.
- out_data and the flags are stable while out_valid && !out_ready.
- overrun and break_det are single-cycle pulses.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY parameter is honoured and the PARITY state exists.
- UART_RX_PARITY_EN undefined:
  - parity logic is not compiled; PARITY is ignored and treated as 0;
  - parity_err is tied to 0;
  - the PARITY state is absent.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT);
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - a function computing CLKS_PER_BIT.
- One natural sub-module, uart_bit_sampler: the synchroniser, per-bit counter and 3-sample majority vote. It outputs bit_value, bit_strobe and fall_edge.

## Test plan
All scenarios use CLK_FREQ=50_000_000 and BAUD=2_500_000 (20 clocks/bit), 8N1 unless noted.
- Frame 0x55 after reset, out_ready=1 → one word 0x55; out_valid high exactly 1 cycle; flags 0.
- Back-to-back frames 0x55 then 0xBC, with no idle gap → both words in order; no overrun.
- 3-cycle low glitch in idle → no out_valid; FSM back in IDLE; next valid frame 0xA3 is received correctly.
- 8E1 with wrong parity bit for 0x0F, macro defined → out_data=0x0F and parity_err=1. Same stimulus with macro undefined → parity_err=0.
- out_ready=0 with two frames 0x11 then 0x22 → out_data stays 0x11; overrun pulses 1 cycle; no frame_err.
- Line held low for 12 bit times → break_det pulses once; no word is delivered. After the line returns high, frame 0x7E is received normally.
- rst asserted for 1 cycle mid-data-bit-4 → all outputs at reset values. The next full frame 0xC3 is received correctly.
